// File: rtl/fir_decim_half.sv
// 2:1 polyphase decimating FIR: 64-tap history, sequential MAC over an external
// combinational coefficient ROM, one rounded and saturated 24-bit output per sample pair.
module fir_decim_half (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [23:0] m_data,
  output logic [6:0]  coef_addr,
  input  logic [15:0] coef_data
);

  localparam logic signed [45:0] SAT_MAX = 46'sd8388607;
  localparam logic signed [45:0] SAT_MIN = -46'sd8388608;
  localparam logic signed [45:0] RND_HALF = 46'sd32768;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [23:0]        hist [64];
  logic [5:0]         wp;
  logic               ph;
  logic [5:0]         rd_ptr;
  logic [5:0]         tap;
  logic signed [23:0] samp_q;
  logic signed [15:0] coef_s;
  logic signed [39:0] prod_q;
  logic signed [45:0] acc;
  logic signed [45:0] acc_sum;
  logic signed [45:0] acc_rnd;
  logic signed [45:0] acc_shift;
  logic [23:0]        result;
  logic [23:0]        m_data_q;
  logic               s_fire;

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both
  // high; valid never waits on ready, and m_valid/m_data hold until the transfer occurs.
  assign s_fire = s_valid & s_ready;
  assign coef_s = coef_data;
  assign m_data = m_data_q;

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (s_fire && ph) state_next = ST_FETCH;
      ST_FETCH: state_next = ST_MAC;
      ST_MAC:   if (tap == 6'd63) state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_OUT;
      ST_OUT:   if (m_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    coef_addr = 7'd0;
    case (state)
      ST_IDLE: s_ready   = 1'b1;
      ST_MAC:  coef_addr = {1'b0, tap};
      ST_OUT:  m_valid   = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sample history and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        hist[i] <= '0;
      end
    end else if (s_fire) begin
      hist[wp] <= s_data;
    end
  end

  // rd_ptr starts at the newest sample and walks backwards one tap per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp     <= '0;
      ph     <= 1'b0;
      rd_ptr <= '0;
    end else if (s_fire) begin
      wp     <= wp + 6'd1;
      ph     <= ~ph;
      rd_ptr <= wp;
    end else if (state == ST_FETCH || state == ST_MAC) begin
      rd_ptr <= rd_ptr - 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap <= '0;
    end else if (state == ST_MAC) begin
      tap <= tap + 6'd1;
    end else begin
      tap <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Multiply-accumulate pipeline: registered read -> registered product -> accumulate
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= '0;
    end else if (state == ST_FETCH || state == ST_MAC) begin
      samp_q <= hist[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
    end else if (state == ST_FETCH) begin
      prod_q <= '0;
    end else if (state == ST_MAC) begin
      prod_q <= 40'(samp_q) * 40'(coef_s);
    end
  end

  assign acc_sum = acc + 46'(prod_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (state == ST_FETCH) begin
      acc <= '0;
    end else if (state == ST_MAC || state == ST_DRAIN) begin
      acc <= acc_sum;
    end
  end

  // The full 64-tap DC gain is about 2.0, so drop 16 fractional bits rather than 15.
  assign acc_rnd   = acc_sum + RND_HALF;
  assign acc_shift = acc_rnd >>> 16;

  always_comb begin
    result = acc_shift[23:0];
    if (acc_shift > SAT_MAX) begin
      result = 24'h7fffff;
    end else if (acc_shift < SAT_MIN) begin
      result = 24'h800000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_q <= '0;
    end else if (state == ST_DRAIN) begin
      m_data_q <= result;
    end
  end

endmodule

// File: tb/tb_fir_decim_half.sv
// Bench for fir_decim_half: impulse vector table, DC, saturation, random gaps,
// output backpressure and reset in the middle of a MAC run, all against a scoreboard.
module tb_fir_decim_half;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [23:0] m_data;
  logic [6:0]  coef_addr;
  logic [15:0] coef_data;

  // ---------------------------------------------------------------------------
  // Clock / reset, DUT and coefficient ROM
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fir_decim_half dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .coef_addr (coef_addr),
    .coef_data (coef_data)
  );

  logic signed [15:0] h [64];
  assign coef_data = (coef_addr < 7'd64) ? h[coef_addr[5:0]] : 16'sd0;

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  logic [23:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          xm [64];
  int          mw       = 0;
  logic        mph      = 1'b0;
  int          ph1_edge = 0;
  int          out_edge = 0;
  logic        mv_prev  = 1'b0;
  longint      last_out = 0;
  int          sat_seen = 0;

  typedef struct {
    logic [23:0] din;
    logic        has_out;
    logic [23:0] dout;
  } vec_t;
  vec_t imp_tab [68];

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) xm[i] = 0;
    mw  = 0;
    mph = 1'b0;
    exp_q.delete();
  endtask

  // Reference: y = sat((sum_k x[n-k]*h[k] + 2^15) >>> 16)
  task automatic model_accept(input logic [23:0] d, output logic fire, output logic [23:0] y);
    longint a;
    xm[mw] = int'($signed(d));
    mw     = (mw + 1) % 64;
    fire   = mph;
    mph    = ~mph;
    y      = '0;
    if (fire) begin
      ph1_edge = cyc;
      a = 0;
      for (int k = 0; k < 64; k++) begin
        a += longint'(xm[(mw - 1 - k + 128) % 64]) * longint'(h[k]);
      end
      a = (a + 32768) >>> 16;
      if (a > 8388607)  a = 8388607;
      if (a < -8388608) a = -8388608;
      y = 24'(a);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send_raw(input logic [23:0] d, input int gap);
    int guard;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    guard   = 0;
    while (!s_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      check("s_ready_timeout", 0, 1);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send(input logic [23:0] d, input int gap);
    logic        fire;
    logic [23:0] y;
    send_raw(d, gap);
    model_accept(d, fire, y);
    if (fire) exp_q.push_back(y);
  endtask

  task automatic run_impulse_table();
    logic        fire;
    logic [23:0] y;
    for (int i = 0; i < 68; i++) begin
      send_raw(imp_tab[i].din, 0);
      model_accept(imp_tab[i].din, fire, y);
      if (imp_tab[i].has_out) exp_q.push_back(imp_tab[i].dout);
    end
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Output monitor: sampled 1 time unit after the falling edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [23:0] e;
    #1;
    if (rst_n) begin
      if (m_valid && !mv_prev) check("latency", cyc - ph1_edge, 66);
      mv_prev = m_valid;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0d, required no output", $signed(m_data));
        end else begin
          e = exp_q.pop_front();
          check("m_data", longint'($signed(m_data)), longint'($signed(e)));
        end
        last_out = longint'($signed(m_data));
        out_edge = cyc + 1;
        if (m_data == 24'h7fffff || m_data == 24'h800000) sat_seen++;
      end
    end else begin
      mv_prev = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int          sum;
    int          guard;
    int          acc_edge;
    logic        stable;
    logic [23:0] held;
    logic        fire;
    logic [23:0] y;

    // Coefficient table: small filler, the known odd-tap values, a strong alternating
    // core that drives full-scale alternating input into clamping, DC gain 65532.
    for (int k = 0; k < 64; k++) h[k] = 16'((k % 5) * 3 - 6);
    for (int k = 24; k < 40; k++) h[k] = (k % 2 == 1) ? 16'sd11000 : -16'sd3000;
    h[1] = -16'sd13; h[3] = -16'sd112; h[5] = -16'sd335; h[7] = -16'sd644; h[63] = -16'sd2;
    sum = 0;
    for (int k = 0; k < 64; k++) sum += int'(h[k]);
    h[31] = 16'(int'(h[31]) + 65532 - sum);

    for (int i = 0; i < 68; i++) begin
      imp_tab[i].din     = (i == 0) ? 24'd65536 : 24'd0;
      imp_tab[i].has_out = (i % 2 == 1);
      imp_tab[i].dout    = (i % 2 == 1 && i < 64) ? 24'(h[i]) : 24'd0;
    end

    model_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    #2;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_coef_addr", coef_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);

    // Impulse: 68 samples -> 34 outputs (odd taps, then two zeros)
    run_impulse_table();
    drain("impulse");

    // DC: settles on the coefficient sum
    for (int i = 0; i < 200; i++) send(24'd65536, 0);
    drain("dc");
    check("dc_final", last_out, 65532);

    // Full-scale alternating input: clamps must hit the rails exactly
    sat_seen = 0;
    for (int i = 0; i < 200; i++) send((i % 2 == 0) ? 24'h7fffff : 24'h800000, 0);
    drain("sat");
    check("sat_clamped_seen", (sat_seen > 0) ? 1 : 0, 1);

    // Random input gaps and values
    for (int i = 0; i < 120; i++) send(24'($urandom_range(0, 24'hffffff)), $urandom_range(0, 10));
    drain("gaps");

    // Output backpressure with an input waiting
    m_ready = 1'b0;
    send(24'd300000, 0);
    send(-24'sd123456, 0);
    s_valid = 1'b1;
    s_data  = 24'd777;
    guard   = 0;
    while (!m_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("stall_m_valid_rise", m_valid, 1);
    held   = m_data;
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (!m_valid || m_data !== held || s_ready) stable = 1'b0;
    end
    check("stall_hold", stable, 1);
    check("stall_coef_addr", coef_addr, 0);
    m_ready = 1'b1;
    guard   = 0;
    while (!s_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    acc_edge = cyc + 1;
    @(negedge clk);
    s_valid = 1'b0;
    model_accept(24'd777, fire, y);
    check("stall_accept_after_out", (acc_edge > out_edge) ? 1 : 0, 1);
    send(24'd5000, 0);
    drain("stall");

    // Reset during MAC cycle 30: nothing emitted, history cleared
    send(24'd400000, 0);
    send(24'd400000, 0);
    repeat (31) @(negedge clk);
    #1;
    check("mac30_coef_addr", coef_addr, 30);
    rst_n = 1'b0;
    #1;
    check("abort_m_valid", m_valid, 0);
    check("abort_coef_addr", coef_addr, 0);
    check("abort_m_data", m_data, 0);
    check("abort_s_ready", s_ready, 1);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_impulse_table();
    drain("impulse2");
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
